// File: rtl/aurora_rx_frame_buffer_pkg.sv
// Shared definitions for the Aurora RX store-and-forward frame buffer.
package aurora_rx_frame_buffer_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned RAM_W     = DATA_W + 1;
  localparam int unsigned TLAST_BIT = DATA_W;

  typedef enum logic [0:0] {
    StAccept  = 1'b0,
    StDiscard = 1'b1
  } wr_state_e;

endpackage

// File: rtl/aurora_rx_frame_buffer_ram.sv
// Simple dual-port RAM, one write port and one synchronous read port (BRAM-inferable).
module aurora_rx_frame_buffer_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 33,
  localparam int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/aurora_rx_frame_buffer.sv
// Store-and-forward frame buffer: accepts every RX word, commits complete frames only,
// drops whole frames on overflow/oversize, and replays committed frames on AXI-Stream.
module aurora_rx_frame_buffer
  import aurora_rx_frame_buffer_pkg::*;
#(
  parameter int unsigned DEPTH           = 512,
  parameter int unsigned MAX_FRAME_WORDS = 128,
  parameter int unsigned CNT_W           = 32,
  localparam int unsigned AddrW = $clog2(DEPTH),
  localparam int unsigned PtrW  = AddrW + 1
) (
  input  logic              m_axis_aclk,
  input  logic              m_axis_reset,
  input  logic              s_axis_tvalid,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [CNT_W-1:0]  frame_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic [PtrW-1:0]   level,
  output logic              drop_pulse
);

  localparam int unsigned LenW = $clog2(MAX_FRAME_WORDS + 1);

  wr_state_e        state_q, state_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  commit_ptr_q, commit_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  fetch_ptr_q, fetch_ptr_d;
  logic [LenW-1:0]  len_q, len_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             drop_pulse_q, drop_pulse_d;

  logic             out_valid_q, out_valid_d;
  logic [RAM_W-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [RAM_W-1:0] skid_data_q, skid_data_d;
  logic             inflight_q, inflight_d;

  logic [PtrW-1:0]  fill;
  logic             full;
  logic             ram_we;
  logic             ram_re;
  logic [RAM_W-1:0] ram_rdata;
  logic             pop;
  logic             avail;
  logic [1:0]       occ;

  // rd_ptr only advances on a downstream handshake, so words parked in the output
  // stages still count as held and cannot be overwritten.
  assign fill  = wr_ptr_q - rd_ptr_q;
  assign full  = (fill == PtrW'(DEPTH));
  assign pop   = out_valid_q & m_axis_tready;
  assign avail = (fetch_ptr_q != commit_ptr_q);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    len_d        = len_q;
    frame_cnt_d  = frame_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    drop_pulse_d = 1'b0;
    ram_we       = 1'b0;
    if (s_axis_tvalid) begin
      unique case (state_q)
        StAccept: begin
          if (full || (len_q == LenW'(MAX_FRAME_WORDS))) begin
            wr_ptr_d     = commit_ptr_q;
            len_d        = '0;
            drop_cnt_d   = drop_cnt_q + CNT_W'(1);
            drop_pulse_d = 1'b1;
            if (!s_axis_tlast) state_d = StDiscard;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PtrW'(1);
            len_d    = len_q + LenW'(1);
            if (s_axis_tlast) begin
              commit_ptr_d = wr_ptr_q + PtrW'(1);
              len_d        = '0;
              frame_cnt_d  = frame_cnt_q + CNT_W'(1);
            end
          end
        end
        StDiscard: begin
          if (s_axis_tlast) state_d = StAccept;
        end
        default: state_d = StAccept;
      endcase
    end
  end

  // Output register plus one skid entry; reads are issued only while out + skid +
  // in-flight stays within two entries, which sustains one word per cycle.
  always_comb begin
    occ          = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(inflight_q) - 2'(pop);
    ram_re       = avail && (occ < 2'd2);
    inflight_d   = ram_re;
    fetch_ptr_d  = fetch_ptr_q + PtrW'(ram_re);
    rd_ptr_d     = rd_ptr_q + PtrW'(pop);
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (pop) begin
      out_valid_d  = skid_valid_q;
      skid_valid_d = 1'b0;
      if (skid_valid_q) out_data_d = skid_data_q;
    end
    if (inflight_q) begin
      if (!out_valid_d) begin
        out_valid_d = 1'b1;
        out_data_d  = ram_rdata;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = ram_rdata;
      end
    end
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_reset) begin
      state_q      <= StAccept;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      len_q        <= '0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      len_q        <= len_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop_pulse_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      inflight_q   <= inflight_d;
    end
  end

  aurora_rx_frame_buffer_ram #(
    .DEPTH (DEPTH),
    .WIDTH (RAM_W)
  ) u_ram (
    .clk_i   (m_axis_aclk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[AddrW-1:0]),
    .wdata_i ({s_axis_tlast, s_axis_tdata}),
    .re_i    (ram_re),
    .raddr_i (fetch_ptr_q[AddrW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q[DATA_W-1:0];
  assign m_axis_tlast  = out_data_q[TLAST_BIT];
  assign frame_count   = frame_cnt_q;
  assign drop_count    = drop_cnt_q;
  assign level         = fill;
  assign drop_pulse    = drop_pulse_q;

endmodule

// File: tb/tb_aurora_rx_frame_buffer.sv
// Bench for aurora_rx_frame_buffer: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a queue-based frame model.
module tb_aurora_rx_frame_buffer;

  // A frame cap of 10 lets the 10-word overflow frames through; oversize uses 14 words.
  localparam int unsigned DEPTH           = 16;
  localparam int unsigned MAX_FRAME_WORDS = 10;
  localparam int unsigned CNT_W           = 32;
  localparam int unsigned LVL_W           = $clog2(DEPTH) + 1;

  logic              m_axis_aclk = 1'b0;
  logic              m_axis_reset;
  logic              s_axis_tvalid;
  logic [31:0]       s_axis_tdata;
  logic              s_axis_tlast;
  logic              m_axis_tvalid;
  logic [31:0]       m_axis_tdata;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic [CNT_W-1:0]  frame_count;
  logic [CNT_W-1:0]  drop_count;
  logic [LVL_W-1:0]  level;
  logic              drop_pulse;

  always #5 m_axis_aclk = ~m_axis_aclk;

  aurora_rx_frame_buffer #(
    .DEPTH           (DEPTH),
    .MAX_FRAME_WORDS (MAX_FRAME_WORDS),
    .CNT_W           (CNT_W)
  ) u_dut (
    .m_axis_aclk   (m_axis_aclk),
    .m_axis_reset  (m_axis_reset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .frame_count   (frame_count),
    .drop_count    (drop_count),
    .level         (level),
    .drop_pulse    (drop_pulse)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: committed words awaiting handshake, words of the frame being received.
  logic [32:0] exp_q[$];
  logic [32:0] part_q[$];
  bit          discarding = 1'b0;
  int unsigned m_frames = 0;
  int unsigned m_drops  = 0;
  bit          m_pulse  = 1'b0;
  int unsigned out_cnt   = 0;
  int unsigned pulse_cnt = 0;
  bit          chk_en    = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  int          rdy_mode = 1;

  always @(negedge m_axis_aclk) begin
    int unsigned lvl;
    if (chk_en) begin
      lvl = exp_q.size() + part_q.size();
      check("level", 32'(level), lvl);
      check("frame_count", frame_count, m_frames);
      check("drop_count", drop_count, m_drops);
      check("drop_pulse", 32'(drop_pulse), 32'(m_pulse));
      if (prev_stall) begin
        check("stall_valid_hold", 32'(m_axis_tvalid), 32'd1);
        check("stall_data_hold", m_axis_tdata, prev_data);
      end
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          check("uncommitted_word_out", 32'(m_axis_tvalid), 32'd0);
        end else begin
          check("tdata", m_axis_tdata, exp_q[0][31:0]);
          check("tlast", 32'(m_axis_tlast), 32'(exp_q[0][32]));
          if (m_axis_tready && !m_axis_reset) begin
            void'(exp_q.pop_front());
            out_cnt++;
          end
        end
      end
      if (drop_pulse) pulse_cnt++;
      prev_stall = m_axis_tvalid && !m_axis_tready && !m_axis_reset;
      prev_data  = m_axis_tdata;
      m_pulse    = 1'b0;
      if (m_axis_reset) begin
        exp_q.delete();
        part_q.delete();
        discarding = 1'b0;
        m_frames   = 0;
        m_drops    = 0;
      end else if (s_axis_tvalid) begin
        if (discarding) begin
          if (s_axis_tlast) discarding = 1'b0;
        end else if (lvl == DEPTH || part_q.size() == MAX_FRAME_WORDS) begin
          part_q.delete();
          m_drops++;
          m_pulse    = 1'b1;
          discarding = !s_axis_tlast;
        end else begin
          part_q.push_back({s_axis_tlast, s_axis_tdata});
          if (s_axis_tlast) begin
            foreach (part_q[i]) exp_q.push_back(part_q[i]);
            part_q.delete();
            m_frames++;
          end
        end
      end
    end
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge m_axis_aclk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        2:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'($urandom);
      endcase
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    @(posedge m_axis_aclk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 1'b0);
  endtask

  task automatic send(input int unsigned n, input logic [31:0] base, input bit with_last);
    for (int i = 0; i < n; i++) drive(1'b1, base + 32'(i), with_last && (i == n - 1));
  endtask

  task automatic do_reset();
    m_axis_reset = 1'b1;
    drive(1'b0, 32'd0, 1'b0);
    m_axis_reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned budget = 0;
    rdy_mode = 1;
    while ((exp_q.size() != 0 || m_axis_tvalid) && budget < 500) begin
      idle(1);
      budget++;
    end
    check({name, "_drain_in_time"}, 32'(budget < 500), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int unsigned base_out;
    int unsigned base_pulse;
    m_axis_reset  = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 32'd0;
    s_axis_tlast  = 1'b0;
    repeat (2) @(posedge m_axis_aclk);
    #1;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_frame_count", frame_count, 32'd0);
    check("rst_drop_count", drop_count, 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_drop_pulse", 32'(drop_pulse), 32'd0);
    m_axis_reset = 1'b0;
    chk_en = 1'b1;

    // Single frame, first word two edges after the edge that takes tlast.
    rdy_mode = 1;
    send(4, 32'h1, 1'b1);
    check("sf_lat_edge0", 32'(m_axis_tvalid), 32'd0);
    idle(1);
    check("sf_lat_edge1", 32'(m_axis_tvalid), 32'd0);
    idle(1);
    check("sf_first_valid", 32'(m_axis_tvalid), 32'd1);
    check("sf_first_data", m_axis_tdata, 32'h1);
    for (int i = 2; i <= 4; i++) begin
      idle(1);
      check("sf_word_valid", 32'(m_axis_tvalid), 32'd1);
      check("sf_word_data", m_axis_tdata, 32'(i));
    end
    check("sf_tlast", 32'(m_axis_tlast), 32'd1);
    idle(1);
    check("sf_end_valid", 32'(m_axis_tvalid), 32'd0);
    check("sf_frame_count", frame_count, 32'd1);

    // Backpressure: tready toggles every cycle.
    rdy_mode = 2;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) drive(1'b1, $urandom, i == 7);
      idle(10);
    end
    rdy_mode = 2;
    repeat (40) idle(1);
    drain("bp");
    check("bp_frame_count", frame_count, 32'd4);
    check("bp_drop_count", drop_count, 32'd0);

    // Overflow: second 10-word frame hits full at its 7th word.
    do_reset();
    rdy_mode = 0;
    base_pulse = pulse_cnt;
    send(10, 32'h100, 1'b1);
    send(6, 32'h200, 1'b0);
    check("ov_level_full", 32'(level), 32'd16);
    drive(1'b1, 32'h206, 1'b0);
    check("ov_drop_pulse", 32'(drop_pulse), 32'd1);
    check("ov_level_rollback", 32'(level), 32'd10);
    send(3, 32'h207, 1'b1);
    idle(3);
    check("ov_one_pulse", pulse_cnt - base_pulse, 32'd1);
    check("ov_drop_count", drop_count, 32'd1);
    check("ov_frame_count", frame_count, 32'd1);
    check("ov_level", 32'(level), 32'd10);
    base_out = out_cnt;
    drain("ov");
    check("ov_words_out", out_cnt - base_out, 32'd10);

    // Oversize: 14-word frame dropped at word 11, then a 2-word frame.
    do_reset();
    rdy_mode = 0;
    send(14, 32'h300, 1'b1);
    check("os_drop_count", drop_count, 32'd1);
    check("os_level", 32'(level), 32'd0);
    send(2, 32'h400, 1'b1);
    idle(1);
    check("os_frame_count", frame_count, 32'd1);
    check("os_level_after", 32'(level), 32'd2);
    base_out = out_cnt;
    drain("os");
    check("os_words_out", out_cnt - base_out, 32'd2);

    // Full exactly when tlast arrives; the next frame is accepted from word one.
    do_reset();
    rdy_mode = 0;
    send(10, 32'h500, 1'b1);
    send(7, 32'h600, 1'b1);
    check("ft_drop_count", drop_count, 32'd1);
    send(3, 32'h700, 1'b1);
    idle(1);
    check("ft_frame_count", frame_count, 32'd2);
    check("ft_level", 32'(level), 32'd13);
    base_out = out_cnt;
    drain("ft");
    check("ft_words_out", out_cnt - base_out, 32'd13);

    // Reset in the middle of a frame.
    rdy_mode = 1;
    send(3, 32'h800, 1'b0);
    do_reset();
    check("rm_level", 32'(level), 32'd0);
    check("rm_tvalid", 32'(m_axis_tvalid), 32'd0);
    base_out = out_cnt;
    send(2, 32'h900, 1'b1);
    idle(1);
    drain("rm");
    check("rm_words_out", out_cnt - base_out, 32'd2);
    check("rm_frame_count", frame_count, 32'd1);

    // Randomized traffic with random tready, including drops.
    rdy_mode = 3;
    for (int f = 0; f < 150; f++) begin
      int unsigned len;
      len = $urandom_range(1, 14);
      for (int i = 0; i < int'(len); i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        drive(1'b1, $urandom, i == int'(len) - 1);
      end
      idle($urandom_range(0, 3));
    end
    drain("rnd");
    check("rnd_level_empty", 32'(level), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
